// File: rtl/stopwatch_digit_chain_if.sv
// stopwatch_digit_chain_if: control/data bundle of the digit chain; lap signals exist only with STOPWATCH_LAP_CAPTURE_EN
interface stopwatch_digit_chain_if #(parameter int NUM_DIGITS = 4);
  logic clear;
  logic load;
  logic tick;
  logic up;
  logic carry_out;
  logic at_zero;
  logic [4*NUM_DIGITS-1:0] load_val;
  logic [4*NUM_DIGITS-1:0] count;
`ifdef STOPWATCH_LAP_CAPTURE_EN
  logic lap;
  logic lap_valid;
  logic [4*NUM_DIGITS-1:0] lap_val;
  modport master(output clear, load, load_val, tick, up, lap, input count, carry_out, at_zero, lap_val, lap_valid);
  modport slave(input clear, load, load_val, tick, up, lap, output count, carry_out, at_zero, lap_val, lap_valid);
`else
  modport master(output clear, load, load_val, tick, up, input count, carry_out, at_zero);
  modport slave(input clear, load, load_val, tick, up, output count, carry_out, at_zero);
`endif
endinterface

// File: rtl/stopwatch_digit_chain.sv
// stopwatch_digit_chain: cascaded per-digit modulus counters; optional lap capture via STOPWATCH_LAP_CAPTURE_EN
module stopwatch_digit_chain #(
  parameter int NUM_DIGITS = 4,
  parameter logic [31:0] MOD_LIST = 32'h0000_6A6A
) (
  input logic clk,
  input logic reset,
  stopwatch_digit_chain_if.slave bus
);
  localparam int W = 4*NUM_DIGITS;
  logic [W-1:0] cnt, nxt;
  logic [NUM_DIGITS-1:0] mx, mn, en;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    localparam logic [3:0] M = MOD_LIST[4*g +: 4];
    localparam logic [3:0] MX = M - 4'd1;
    logic [3:0] d, lv;
    assign d = cnt[4*g +: 4];
    assign lv = bus.load_val[4*g +: 4];
    assign mx[g] = d == MX;
    assign mn[g] = d == 4'd0;
    // a digit steps only when every lower digit is about to wrap
    if (g == 0) begin : g_lsd
      assign en[g] = 1'b1;
    end else begin : g_upper
      assign en[g] = bus.up ? &mx[g-1:0] : &mn[g-1:0];
    end
    assign nxt[4*g +: 4] = bus.clear ? 4'd0 :
                           bus.load ? (lv >= M ? MX : lv) :
                           !(bus.tick && en[g]) ? d :
                           bus.up ? (mx[g] ? 4'd0 : d + 4'd1) :
                           (mn[g] ? MX : d - 4'd1);
  end
  always_ff @(posedge clk) begin
    if (!reset) cnt <= '0;
    else cnt <= nxt;
  end
  assign bus.count = cnt;
  assign bus.at_zero = &mn;
  assign bus.carry_out = bus.tick & !bus.clear & !bus.load & reset & (bus.up ? &mx : &mn);
`ifdef STOPWATCH_LAP_CAPTURE_EN
  logic [W-1:0] lap_q;
  logic lap_v;
  always_ff @(posedge clk) begin
    if (!reset || bus.clear) begin
      lap_q <= '0;
      lap_v <= 1'b0;
    end else if (bus.lap) begin
      lap_q <= nxt;
      lap_v <= 1'b1;
    end
  end
  assign bus.lap_val = lap_q;
  assign bus.lap_valid = lap_v;
`endif
endmodule

// File: tb/tb_stopwatch_digit_chain.sv
// tb_stopwatch_digit_chain: scoreboard bench for the default MM:SS chain; lap checks when STOPWATCH_LAP_CAPTURE_EN is defined
module tb_stopwatch_digit_chain;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];
  always #5 clk = ~clk;
  stopwatch_digit_chain_if #(.NUM_DIGITS(4)) bus();
  stopwatch_digit_chain #(.NUM_DIGITS(4), .MOD_LIST(32'h0000_6A6A)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int to_sec(input logic [15:0] c);
    return int'(c[3:0]) + 10*int'(c[7:4]) + 60*int'(c[11:8]) + 600*int'(c[15:12]);
  endfunction
  function automatic logic [15:0] to_bcd(input int s);
    return {4'(s/600), 4'((s/60)%10), 4'((s%60)/10), 4'(s%10)};
  endfunction
  task automatic cyc(input logic rs, input logic clr, input logic ld, input logic [15:0] lv,
                     input logic tk, input logic u, input logic [15:0] exp_cnt, input logic exp_cy);
    @(negedge clk);
    reset = rs;
    bus.clear = clr;
    bus.load = ld;
    bus.load_val = lv;
    bus.tick = tk;
    bus.up = u;
    #1 chk("carry_out", {31'd0, bus.carry_out}, {31'd0, exp_cy});
    exp_q.push_back(exp_cnt);
    @(posedge clk);
    #2;
  endtask
  initial begin
    logic [15:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("count", {16'd0, bus.count}, {16'd0, e});
        chk("at_zero", {31'd0, bus.at_zero}, {31'd0, e == 16'h0});
      end
    end
  end
  initial begin
    int s;
    logic tk, u, cy;
    bus.clear = 1'b0;
    bus.load = 1'b0;
    bus.load_val = '0;
    bus.tick = 1'b0;
    bus.up = 1'b1;
`ifdef STOPWATCH_LAP_CAPTURE_EN
    bus.lap = 1'b0;
`endif
    cyc(0, 0, 0, 16'h0000, 1, 1, 16'h0000, 0);
    cyc(0, 0, 0, 16'h0000, 1, 1, 16'h0000, 0);
    cyc(1, 0, 0, 16'h0000, 1, 1, 16'h0001, 0);
    cyc(1, 0, 0, 16'h0000, 0, 0, 16'h0001, 0);
    cyc(1, 0, 1, 16'h5959, 0, 1, 16'h5959, 0);
    cyc(1, 0, 0, 16'h0000, 1, 1, 16'h0000, 1);
    cyc(1, 0, 1, 16'h1000, 0, 1, 16'h1000, 0);
    cyc(1, 0, 0, 16'h0000, 1, 0, 16'h0959, 0);
    cyc(1, 0, 1, 16'h0000, 0, 1, 16'h0000, 0);
    cyc(1, 0, 0, 16'h0000, 1, 0, 16'h5959, 1);
    cyc(1, 0, 1, 16'hF7CB, 1, 1, 16'h5759, 0);
    cyc(1, 0, 1, 16'h0123, 0, 1, 16'h0123, 0);
    cyc(1, 1, 1, 16'h0456, 1, 1, 16'h0000, 0);
    cyc(1, 0, 1, 16'h0123, 0, 1, 16'h0123, 0);
    cyc(0, 0, 1, 16'h0456, 1, 1, 16'h0000, 0);
    cyc(1, 0, 1, 16'h5955, 0, 1, 16'h5955, 0);
    s = to_sec(16'h5955);
    for (int i = 0; i < 60; i++) begin
      tk = $urandom_range(0, 3) != 0;
      u = i < 30 ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 4) == 0);
      cy = tk && (u ? s == 3599 : s == 0);
      if (tk) s = u ? (s + 1) % 3600 : (s + 3599) % 3600;
      cyc(1, 0, 0, 16'h0000, tk, u, to_bcd(s), cy);
    end
    cyc(1, 0, 1, 16'h0002, 0, 1, 16'h0002, 0);
    s = 2;
    for (int i = 0; i < 10; i++) begin
      cy = s == 0;
      s = (s + 3599) % 3600;
      cyc(1, 0, 0, 16'h0000, 1, 0, to_bcd(s), cy);
    end
`ifdef STOPWATCH_LAP_CAPTURE_EN
    cyc(1, 0, 1, 16'h0008, 0, 1, 16'h0008, 0);
    chk("lap_valid_pre", {31'd0, bus.lap_valid}, 32'd0);
    bus.lap = 1'b1;
    cyc(1, 0, 0, 16'h0000, 1, 1, 16'h0009, 0);
    bus.lap = 1'b0;
    chk("lap_val", {16'd0, bus.lap_val}, 32'h0009);
    chk("lap_valid", {31'd0, bus.lap_valid}, 32'd1);
    cyc(1, 0, 0, 16'h0000, 1, 1, 16'h0010, 0);
    cyc(1, 0, 0, 16'h0000, 1, 1, 16'h0011, 0);
    cyc(1, 0, 1, 16'h0300, 0, 1, 16'h0300, 0);
    chk("lap_hold", {16'd0, bus.lap_val}, 32'h0009);
    cyc(1, 1, 0, 16'h0000, 0, 1, 16'h0000, 0);
    chk("lap_clr_val", {16'd0, bus.lap_val}, 32'h0);
    chk("lap_clr_valid", {31'd0, bus.lap_valid}, 32'd0);
`endif
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
